// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper and the Tabla/Mux blocks it exercises.
// Provides the sweep state enum and the select-width to vector-count derivation.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

  localparam int unsigned DEF_N_SEL = 3;

  function automatic int unsigned n_vec_of(input int unsigned n_sel);
    return 32'd1 << n_sel;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// Per-vector settle timer: expire strobes once every HOLD_CYCLES cycles while running.
// Loading (while idle) re-arms it so the first vector gets a full hold window.
module truth_table_sweeper_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_run && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load || o_expire) begin
      r_cnt <= RELOAD;
    end else if (i_run) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every select combination into a combinational mux, captures y_in per vector
// into table_out, and compares the captured table against the expected table latched at start.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter  int N_SEL       = DEF_N_SEL,
  parameter  int HOLD_CYCLES = 1,
  localparam int N_VEC       = int'(n_vec_of(N_SEL))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_VEC-1:0] expected,
  input  logic             y_in,
  output logic [N_SEL-1:0] sel_out,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic             match
);

  sweep_state_e r_state;
  sweep_state_e w_state_nxt;

  logic [N_SEL-1:0] r_sel;
  logic [N_VEC-1:0] r_table;
  logic [N_VEC-1:0] r_exp;
  logic             r_match;
  logic             r_busy;
  logic             r_done;

  logic             w_expire;
  logic             w_last;
  logic [N_VEC-1:0] w_table_cap;

  assign w_last = (r_sel == N_SEL'(N_VEC - 1));

  truth_table_sweeper_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == ST_IDLE),
    .i_run    (r_state == ST_RUN),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_expire && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Table including the bit being captured this edge, so match sees the final vector.
  always_comb begin
    w_table_cap        = r_table;
    w_table_cap[r_sel] = y_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel   <= '0;
      r_table <= '0;
      r_exp   <= '0;
      r_match <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_DONE);
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sel   <= '0;
            r_table <= '0;
            r_exp   <= expected;
            r_match <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_expire) begin
            r_table <= w_table_cap;
            if (w_last) begin
              r_match <= (w_table_cap == r_exp);
            end else begin
              r_sel <= r_sel + N_SEL'(1);
            end
          end
        end
        ST_DONE: r_sel <= '0;
        default: r_sel <= '0;
      endcase
    end
  end

  assign sel_out   = r_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign match     = r_match;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (HOLD_CYCLES 1 and 3) driving bench-side lookup muxes,
// checked cycle by cycle against a timeline model derived from the sweep rules.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start1, start3;
  logic [7:0] exp1, exp3, func1, func3;
  logic [2:0] sel1, sel3;
  logic       busy1, busy3, done1, done3, match1, match3;
  logic [7:0] tab1, tab3;
  logic       y1, y3;
  logic       use3;

  assign y1 = func1[sel1];
  assign y3 = func3[sel3];

  truth_table_sweeper #(.N_SEL(3), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .expected(exp1), .y_in(y1),
    .sel_out(sel1), .busy(busy1), .done(done1), .table_out(tab1), .match(match1)
  );

  truth_table_sweeper #(.N_SEL(3), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .expected(exp3), .y_in(y3),
    .sel_out(sel3), .busy(busy3), .done(done3), .table_out(tab3), .match(match3)
  );

  logic [2:0] o_sel;
  logic       o_busy, o_done, o_match;
  logic [7:0] o_tab;
  assign o_sel   = use3 ? sel3   : sel1;
  assign o_busy  = use3 ? busy3  : busy1;
  assign o_done  = use3 ? done3  : done1;
  assign o_match = use3 ? match3 : match1;
  assign o_tab   = use3 ? tab3   : tab1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic set_start(input logic v);
    if (use3) start3 = v;
    else      start1 = v;
  endtask

  // One full sweep; restart_mask bit k raises start for edge k of the sweep (must be ignored).
  task automatic sweep(input int h, input logic [7:0] f, input logic [7:0] e,
                       input logic [31:0] restart_mask);
    int n;
    logic [8:0] m;
    n    = 8 * h;
    use3 = (h == 3);
    @(negedge clk);
    if (use3) begin func3 = f; exp3 = e; end
    else      begin func1 = f; exp1 = e; end
    set_start(1'b1);
    @(negedge clk);
    // The latched copy must govern, not the live input.
    if (use3) exp3 = ~e; else exp1 = ~e;
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        m = (9'd1 << (k / h)) - 9'd1;
        chk("run_busy",  32'(o_busy),  32'd1);
        chk("run_done",  32'(o_done),  32'd0);
        chk("run_sel",   32'(o_sel),   32'(k / h));
        chk("run_table", 32'(o_tab),   32'(f & m[7:0]));
        chk("run_match", 32'(o_match), 32'd0);
      end else begin
        chk("done_busy",  32'(o_busy),  32'd0);
        chk("done_pulse", 32'(o_done),  32'd1);
        chk("done_sel",   32'(o_sel),   32'd7);
        chk("done_table", 32'(o_tab),   32'(f));
        chk("done_match", 32'(o_match), 32'(f == e));
      end
      set_start(restart_mask[k + 1]);
      @(negedge clk);
    end
    set_start(1'b0);
    chk("idle_busy",  32'(o_busy),  32'd0);
    chk("idle_done",  32'(o_done),  32'd0);
    chk("idle_sel",   32'(o_sel),   32'd0);
    chk("idle_table", 32'(o_tab),   32'(f));
    chk("idle_match", 32'(o_match), 32'(f == e));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] f, e;
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; use3 = 1'b0;
    exp1 = 8'hA5; exp3 = 8'h5A; func1 = 8'hFF; func3 = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_sel",   32'(sel1),   32'd0);
    chk("rst_busy",  32'(busy1),  32'd0);
    chk("rst_done",  32'(done1),  32'd0);
    chk("rst_table", 32'(tab1),   32'd0);
    chk("rst_match", 32'(match1), 32'd0);
    chk("rst3_busy", 32'(busy3),  32'd0);
    chk("rst3_table",32'(tab3),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    sweep(1, 8'h96, 8'h96, 32'h0);
    sweep(1, 8'h73, 8'h73, 32'h0);
    sweep(1, 8'h73, 8'h72, 32'h0);
    sweep(3, 8'hFF, 8'hFF, 32'h0);
    sweep(1, 8'h96, 8'h96, 32'h108);
    sweep(3, 8'h3C, 8'h3D, 32'h00A0_0210);

    for (int r = 0; r < 8; r++) begin
      f = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
      sweep(($urandom_range(0, 3) == 0) ? 3 : 1, f, e, 32'h0);
    end

    // start held high: sweeps repeat every 10 cycles
    use3 = 1'b0;
    f = 8'($urandom);
    func1 = f; exp1 = f;
    start1 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("cont_done", 32'(done1), 32'((k % 10) == 8));
      chk("cont_busy", 32'(busy1), 32'((k % 10) < 8));
      if ((k % 10) < 8) chk("cont_sel", 32'(sel1), 32'(k % 10));
      if ((k % 10) == 8) chk("cont_match", 32'(match1), 32'd1);
    end
    start1 = 1'b0;
    repeat (3) @(negedge clk);

    // reset at cycle 4 of a sweep aborts without a done pulse
    func1 = 8'h96; exp1 = 8'h96;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_sel",   32'(sel1),   32'd0);
    chk("abort_busy",  32'(busy1),  32'd0);
    chk("abort_done",  32'(done1),  32'd0);
    chk("abort_table", 32'(tab1),   32'd0);
    chk("abort_match", 32'(match1), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done1), 32'd0);
      chk("abort_idle",   32'(busy1), 32'd0);
    end
    sweep(1, 8'h96, 8'h96, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of the truth-table multiplexer blocks. It drives their select inputs (inA/inB/inC) through every combination, samples the mux output once per vector, and assembles the captured truth table into a register. It also compares the result against an expected table. This lets a lab board or bench check any Tabla*_* implementation with one start pulse.

## Interface
- N_SEL, default 3: number of select bits driven; N_VEC = 2**N_SEL vectors per sweep.
- HOLD_CYCLES, default 1 (legal ≥1): clock cycles each vector is held before sampling, covering mux settling.

- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high; one clock domain only.
- start  input  1  request a sweep; accepted only in IDLE.
- expected  input  N_VEC  reference truth table; bit i = required output for select value i; latched on start acceptance.
- y_in  input  1  output of the downstream mux under test.
- sel_out  output  N_SEL  select vector to the mux; sel_out[0] is the LSB select (S0), sel_out[N_SEL-1] the MSB select.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  N_VEC  captured truth table; bit i = y_in sampled while sel_out == i.
- match  output  1  table_out == latched expected, valid from done onward.

## Operation
- States: IDLE, RUN, DONE.
- Reset (synchronous, any state): state=IDLE, sel_out=0, hold_cnt=0, busy=0, done=0, table_out=0, match=0, expected latch=0.
- IDLE: on an edge with start=1 → RUN. Set sel_out=0, hold_cnt=0, clear table_out to 0, latch expected, and clear match.
- RUN, at each edge:
  - If hold_cnt < HOLD_CYCLES-1: hold_cnt++; sel_out unchanged.
  - Else: table_out[sel_out] <= y_in.
    - If sel_out == N_VEC-1: → DONE; match <= (table_out with the final bit written) == expected latch.
    - Otherwise: sel_out++ and hold_cnt=0.
- DONE: lasts exactly one cycle. done=1. On the next edge → IDLE with sel_out=0.
- start is ignored in RUN and DONE; there is no queuing. If start is held high continuously, a new sweep begins on the first edge spent in IDLE after DONE.
- table_out and match hold their values from DONE until the next accepted start or reset.
- sel_out never wraps inside a sweep. The N_SEL-bit increment from N_VEC-1 never occurs.
- Reset mid-sweep: abort immediately to reset values; no done pulse is issued.

## Timing
- busy, done and match are registered outputs (state decode is registered, no combinational path from inputs).
- Start accepted at edge 0. Then:
  - sel_out = i holds for the HOLD_CYCLES cycles after edge i·HOLD_CYCLES.
  - y_in is sampled at edge (i+1)·HOLD_CYCLES.
- busy is high for exactly N_VEC·HOLD_CYCLES cycles. With defaults this is 8 cycles: busy rises after edge 0 and falls at edge 8.
- done is high for the single cycle following edge N_VEC·HOLD_CYCLES. table_out and match are valid in that same cycle.
- Minimum start-to-start spacing is N_VEC·HOLD_CYCLES + 2 cycles.
- The downstream mux is combinational, so y_in must be stable HOLD_CYCLES cycles after a sel_out change.

## Structure
- Shared package: the state enum (IDLE/RUN/DONE) and an N_VEC derivation function/constant. The other Tabla/Mux blocks reuse the package.
- One natural sub-module: hold_timer. It holds the HOLD_CYCLES down-counter and emits a one-cycle `expire` strobe; the FSM, select counter and capture register stay in truth_table_sweeper.

## Test plan
- Defaults, y_in driven by a bench lookup of sel_out into 8'h96 (Tabla01 function, sel_out[0]=S0), expected=8'h96. Pulse start → sel_out steps 0..7 one per cycle; done at cycle 8 after acceptance; table_out=8'h96; match=1.
- Same sweep with expected=8'h73 while y_in implements 8'h73 (Tabla02 ordering) → table_out=8'h73, match=1. Then repeat with expected=8'h72 → match=0.
- HOLD_CYCLES=3, y_in = constant 1 → each sel_out value held 3 cycles; busy high 24 cycles; table_out=8'hFF.
- Assert start again at cycles 3 and 8 of a running sweep → ignored; exactly one done pulse. Holding start high continuously → back-to-back sweeps spaced 10 cycles apart.
- Assert reset at cycle 4 of a sweep → next cycle: sel_out=0, busy=0, table_out=0, match=0, no done. A fresh start afterward completes normally.
- Change expected mid-sweep from 8'h96 to 8'h00 → the value latched at start governs: match=1 for a y_in implementing 8'h96.
